// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame controller.
// Frame states, parity selectors and line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator for one data word.
// Even parity is the XOR reduction; odd parity is its inverse.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  logic red;

  // XOR-reduce the word, invert for odd parity
  always_comb begin
    red       = ^data_i;
    par_bit_o = (par_typ_i == PAR_ODD) ? ~red : red;
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, serialized data, optional parity,
// stop bits; aborts the data phase if the serializer never finishes.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Data_Valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tmo_err
);

  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic          SB_LAST  = (STOP_BITS == 2);

  state_e        state_q, state_d;
  logic          par_bit_q, par_bit_d;
  logic          par_en_q, par_en_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          tmo_err_q, tmo_err_d;
  logic          par_calc;

  // PAR_TYP is folded into the latched parity bit, so it needs no
  // separate register.
  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .data_i   (P_DATA),
    .par_typ_i(PAR_TYP),
    .par_bit_o(par_calc)
  );

  // State and latch registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // Next-state logic, acceptance latching and counters
  always_comb begin
    state_d    = state_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    tmo_cnt_d  = tmo_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tmo_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stop_cnt_d = 1'b0;
        if (Data_Valid) begin
          par_bit_d = par_calc;
          par_en_d  = PAR_EN;
          state_d   = START;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        if (tmo_cnt_q != TMO_LAST)
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (ser_done) begin
          state_d    = par_en_q ? PARITY : STOP;
          stop_cnt_d = 1'b0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tmo_err_d  = 1'b1;
        end
      end
      PARITY: begin
        stop_cnt_d = 1'b0;
        state_d    = STOP;
      end
      STOP: begin
        if (stop_cnt_q == SB_LAST)
          state_d = IDLE;
        else
          stop_cnt_d = stop_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line mux and status decode from the registered state
  always_comb begin
    TX_OUT = IDLE_LVL;
    unique case (state_q)
      IDLE:    TX_OUT = IDLE_LVL;
      START:   TX_OUT = START_LVL;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = par_bit_q;
      STOP:    TX_OUT = STOP_LVL;
      default: TX_OUT = IDLE_LVL;
    endcase
    busy    = (state_q != IDLE);
    ser_en  = (state_q == START) || (state_q == DATA);
    tmo_err = tmo_err_q;
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: serializer model plus a per-cycle
// expected-frame model built from the framing rules.
module tb_uart_tx_frame_ctrl;

  localparam int SB  = 2;
  localparam int TMO = 16;

  typedef struct packed {
    logic tx;
    logic bsy;
    logic en;
    logic tmo;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Data_Valid = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic       TX_OUT;
  logic       busy;
  logic       tmo_err;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int inj    = 0;

  bit         stall = 1'b0;
  int         ser_idx = 0;
  logic [7:0] ser_word = 8'h00;

  uart_tx_frame_ctrl #(
    .DATA_WIDTH  (8),
    .STOP_BITS   (SB),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Data_Valid(Data_Valid),
    .P_DATA    (P_DATA),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .TX_OUT    (TX_OUT),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 CLK = ~CLK;

  // Serializer: loads on accepted Data_Valid; first enabled cycle
  // primes it, then bit i appears on enabled cycle i+1.
  always @(posedge CLK) begin
    if (!busy && Data_Valid) begin
      ser_word <= P_DATA;
      ser_idx  <= 0;
    end else if (ser_en) begin
      ser_idx <= ser_idx + 1;
    end
  end

  always_comb begin
    ser_data = 1'b1;
    if (ser_idx >= 1 && ser_idx <= 8)
      ser_data = ser_word[3'(ser_idx - 1)];
    ser_done = !stall && (ser_idx == 8);
  end

  // Upstream protocol monitor: Data_Valid while busy
  always @(posedge CLK) begin
    if (RST && busy && Data_Valid)
      viol <= viol + 1;
  end

  task automatic chk(input string tag, input int idx,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] obs=%b exp=%b", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int k,
                         input exp_t e);
    chk({tag, "_tx"},   k, TX_OUT,  e.tx);
    chk({tag, "_busy"}, k, busy,    e.bsy);
    chk({tag, "_en"},   k, ser_en,  e.en);
    chk({tag, "_tmo"},  k, tmo_err, e.tmo);
  endtask

  // Called at a negedge; leaves off at the negedge of the idle cycle
  // that follows the frame.
  task automatic run_frame(input logic [7:0] d, input bit pen,
                           input bit ptyp, input bit to,
                           input int inj_at, input int tog_at);
    exp_t q[$];
    int   n;
    q.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
    n = to ? TMO : 8;
    for (int i = 0; i < n; i++)
      q.push_back('{(i < 8) ? d[i] : 1'b1, 1'b1, 1'b1, 1'b0});
    if (!to && pen)
      q.push_back('{(^d) ^ ptyp, 1'b1, 1'b0, 1'b0});
    for (int s = 0; s < SB; s++)
      q.push_back('{1'b1, 1'b1, 1'b0, to && (s == 0)});
    q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});

    stall      = to;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    P_DATA     = 8'($urandom);
    for (int k = 0; k < q.size(); k++) begin
      chk_all("frm", k, q[k]);
      Data_Valid = 1'b0;
      if (k == inj_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'($urandom);
        inj++;
      end
      if (k == tog_at) begin
        PAR_TYP = ~PAR_TYP;
        PAR_EN  = ~PAR_EN;
      end
      if (k != q.size() - 1)
        @(negedge CLK);
    end
    Data_Valid = 1'b0;
    stall      = 1'b0;
  endtask

  initial begin
    exp_t idle_e;
    idle_e = '{1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk_all("idle", i, idle_e);
    end

    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, -1);
    @(negedge CLK);
    run_frame(8'h01, 1'b1, 1'b1, 1'b0, -1, 5);
    @(negedge CLK);
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, -1, 3);
    @(negedge CLK);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 3, -1);
    chk_int("viol", viol, inj);

    @(negedge CLK);
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, -1);
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, -1);

    for (int r = 0; r < 8; r++) begin
      @(negedge CLK);
      run_frame(8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, -1, -1);
    end

    @(negedge CLK);
    P_DATA     = 8'hC3;
    PAR_EN     = 1'b1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_busy", 0, busy, 1'b1);
    RST = 1'b0;
    @(negedge CLK);
    chk_all("rst", 0, idle_e);
    RST = 1'b1;
    @(negedge CLK);
    chk_all("rst", 1, idle_e);
    run_frame(8'h96, 1'b1, 1'b1, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
